// File: rtl/block_transfer_sequencer.sv
// LDM/STM block-transfer sequencer: walks a register list and runs one memory word
// transfer per listed register, then optionally writes the final base back.
module block_transfer_sequencer #(
  parameter int WORD_BYTES = 4,
  parameter int LIST_W     = 16,
  localparam int IDX_W     = $clog2(LIST_W),
  localparam int CNT_W     = $clog2(LIST_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic [LIST_W-1:0] reg_list,
  input  logic [31:0]       base_addr,
  input  logic [IDX_W-1:0]  base_reg,
  input  logic              up,
  input  logic              pre,
  input  logic              writeback,
  output logic [IDX_W-1:0]  rf_src,
  input  logic [31:0]       rf_data,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              WB_EN,
  output logic [IDX_W-1:0]  WB_Dest,
  output logic [31:0]       WB_Res,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, XFER, BASE_WB, DONE} state_t;

  localparam logic [31:0] STEP = 32'(WORD_BYTES);

  state_t              state_q, state_d;
  logic [LIST_W-1:0]   pend_q, pend_d, list_q, list_d;
  logic [IDX_W-1:0]    rf_src_q, rf_src_d, base_reg_q, base_reg_d;
  logic [IDX_W-1:0]    wb_dest_q, wb_dest_d;
  logic [31:0]         addr_q, addr_d, final_q, final_d, wb_res_q, wb_res_d;
  logic                rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic                wb_en_q, wb_en_d, busy_q, busy_d, done_q, done_d;
  logic                is_load_q, is_load_d, wb_q, wb_d, bw_sent_q, bw_sent_d;

  logic [LIST_W-1:0]   rem;
  logic [31:0]         span;

  function automatic logic [IDX_W-1:0] lowest(input logic [LIST_W-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [LIST_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < LIST_W; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    list_d     = list_q;
    rf_src_d   = rf_src_q;
    base_reg_d = base_reg_q;
    addr_d     = addr_q;
    final_d    = final_q;
    rd_en_d    = rd_en_q;
    wr_en_d    = wr_en_q;
    is_load_d  = is_load_q;
    wb_d       = wb_q;
    bw_sent_d  = bw_sent_q;
    busy_d     = busy_q;
    wb_en_d    = 1'b0;
    wb_dest_d  = wb_dest_q;
    wb_res_d   = wb_res_q;
    done_d     = 1'b0;
    span       = 32'(popcount(reg_list)) * STEP;
    rem        = pend_q & ~(LIST_W'(1) << rf_src_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          list_d     = reg_list;
          pend_d     = reg_list;
          is_load_d  = is_load;
          wb_d       = writeback;
          base_reg_d = base_reg;
          busy_d     = 1'b1;
          final_d    = up ? base_addr + span : base_addr - span;
          case ({up, pre})
            2'b10:   addr_d = base_addr;
            2'b11:   addr_d = base_addr + STEP;
            2'b00:   addr_d = base_addr - span + STEP;
            default: addr_d = base_addr - span;
          endcase
          if (reg_list == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = XFER;
            rd_en_d  = is_load;
            wr_en_d  = !is_load;
            rf_src_d = lowest(reg_list);
          end
        end
      end

      XFER: begin
        if (mem_ready) begin
          pend_d = rem;
          addr_d = addr_q + STEP;
          if (is_load_q) begin
            wb_en_d   = 1'b1;
            wb_dest_d = rf_src_q;
            wb_res_d  = mem_rdata;
          end
          if (rem == '0) begin
            rd_en_d = 1'b0;
            wr_en_d = 1'b0;
            if (wb_q && !(is_load_q && list_q[base_reg_q])) begin
              state_d = BASE_WB;
              // A load's final write-back occupies WB_EN next cycle, so the base write waits.
              if (!is_load_q) begin
                wb_en_d   = 1'b1;
                wb_dest_d = base_reg_q;
                wb_res_d  = final_q;
              end
              bw_sent_d = !is_load_q;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            rf_src_d = lowest(rem);
          end
        end
      end

      BASE_WB: begin
        if (!bw_sent_q) begin
          wb_en_d   = 1'b1;
          wb_dest_d = base_reg_q;
          wb_res_d  = final_q;
          bw_sent_d = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      list_q     <= '0;
      rf_src_q   <= '0;
      base_reg_q <= '0;
      addr_q     <= '0;
      final_q    <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      is_load_q  <= 1'b0;
      wb_q       <= 1'b0;
      bw_sent_q  <= 1'b0;
      busy_q     <= 1'b0;
      wb_en_q    <= 1'b0;
      wb_dest_q  <= '0;
      wb_res_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      list_q     <= list_d;
      rf_src_q   <= rf_src_d;
      base_reg_q <= base_reg_d;
      addr_q     <= addr_d;
      final_q    <= final_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      is_load_q  <= is_load_d;
      wb_q       <= wb_d;
      bw_sent_q  <= bw_sent_d;
      busy_q     <= busy_d;
      wb_en_q    <= wb_en_d;
      wb_dest_q  <= wb_dest_d;
      wb_res_q   <= wb_res_d;
      done_q     <= done_d;
    end
  end

  assign rf_src       = rf_src_q;
  assign mem_read_en  = rd_en_q;
  assign mem_write_en = wr_en_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = rf_data;
  assign WB_EN        = wb_en_q;
  assign WB_Dest      = wb_dest_q;
  assign WB_Res       = wb_res_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Directed bench for block_transfer_sequencer: STM/LDM walks, stalls, empty list, mid-run reset.
module tb_block_transfer_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, is_load, up, pre, writeback, mem_ready;
  logic [15:0] reg_list;
  logic [31:0] base_addr, rf_data, mem_rdata, mem_addr, mem_wdata, WB_Res;
  logic [3:0]  base_reg, rf_src, WB_Dest;
  logic        mem_read_en, mem_write_en, WB_EN, busy, done;

  logic [31:0]  rf [16];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [127:0] obs, exp;

  always #5 clk = ~clk;

  assign rf_data = rf[rf_src];

  block_transfer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .reg_list(reg_list),
    .base_addr(base_addr), .base_reg(base_reg), .up(up), .pre(pre), .writeback(writeback),
    .rf_src(rf_src), .rf_data(rf_data), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .WB_EN(WB_EN), .WB_Dest(WB_Dest), .WB_Res(WB_Res), .busy(busy), .done(done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic ld, input logic [15:0] lst, input logic [31:0] ba,
                        input logic [3:0] br, input logic u, input logic p, input logic w);
    is_load = ld; reg_list = lst; base_addr = ba; base_reg = br;
    up = u; pre = p; writeback = w; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    obs = {busy, done, WB_EN, mem_read_en, mem_write_en, mem_addr, WB_Res, WB_Dest, rf_src};
    exp = '0;
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL reset_state: got %h want %h", obs, exp); end
    rst = 1'b0;
    tick();
    obs = {busy, done}; exp = '0;
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL idle_after_reset: got %h want %h", obs, exp); end
    $display("reset: state checked");
  endtask

  task automatic test_stm;
    logic [31:0] addrs [3];
    addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h108;
    mem_ready = 1'b1;
    launch(1'b0, 16'h000E, 32'h100, 4'd13, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      obs = {mem_read_en, mem_write_en, rf_src, mem_addr, mem_wdata, WB_EN, busy};
      exp = {1'b0, 1'b1, 4'(i + 1), addrs[i], rf[i + 1], 1'b0, 1'b1};
      n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL stm_xfer%0d: got %h want %h", i, obs, exp); end
      $display("stm: xfer %0d addr=%h wdata=%h", i, mem_addr, mem_wdata);
      tick();
    end
    obs = {WB_EN, WB_Dest, WB_Res, mem_write_en, mem_read_en, done};
    exp = {1'b1, 4'd13, 32'h10C, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL stm_base_wb: got %h want %h", obs, exp); end
    tick();
    obs = {done, busy, WB_EN}; exp = {1'b1, 1'b1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL stm_done: got %h want %h", obs, exp); end
    tick();
    obs = {done, busy}; exp = '0;
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL stm_idle: got %h want %h", obs, exp); end
  endtask

  task automatic test_ldm_down;
    mem_ready = 1'b1;
    launch(1'b1, 16'h8001, 32'h200, 4'd4, 1'b0, 1'b1, 1'b1);
    mem_rdata = 32'hAAAA0000;
    obs = {mem_read_en, mem_write_en, rf_src, mem_addr, WB_EN};
    exp = {1'b1, 1'b0, 4'd0, 32'h1F8, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL ldm_xfer0: got %h want %h", obs, exp); end
    tick();
    mem_rdata = 32'hBBBB0000;
    obs = {mem_read_en, rf_src, mem_addr, WB_EN, WB_Dest, WB_Res};
    exp = {1'b1, 4'd15, 32'h1FC, 1'b1, 4'd0, 32'hAAAA0000};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL ldm_xfer1: got %h want %h", obs, exp); end
    tick();
    mem_rdata = 32'h0;
    obs = {mem_read_en, WB_EN, WB_Dest, WB_Res, done};
    exp = {1'b0, 1'b1, 4'd15, 32'hBBBB0000, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL ldm_last_wb: got %h want %h", obs, exp); end
    tick();
    obs = {WB_EN, WB_Dest, WB_Res, done};
    exp = {1'b1, 4'd4, 32'h1F8, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL ldm_base_wb: got %h want %h", obs, exp); end
    tick();
    obs = {done, busy, WB_EN}; exp = {1'b1, 1'b1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL ldm_done: got %h want %h", obs, exp); end
    tick();
    $display("ldm: decrement-before transfer finished, busy=%0d", busy);
  endtask

  task automatic test_ldm_base_in_list;
    mem_ready = 1'b1;
    launch(1'b1, 16'h0006, 32'h300, 4'd2, 1'b1, 1'b0, 1'b1);
    mem_rdata = 32'h11;
    tick();
    mem_rdata = 32'h22;
    obs = {mem_addr, rf_src, WB_EN, WB_Dest, WB_Res};
    exp = {32'h304, 4'd2, 1'b1, 4'd1, 32'h11};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL inlist_xfer1: got %h want %h", obs, exp); end
    tick();
    obs = {done, WB_EN, WB_Dest, WB_Res};
    exp = {1'b1, 1'b1, 4'd2, 32'h22};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL inlist_no_base_wb: got %h want %h", obs, exp); end
    tick();
    obs = {busy, WB_EN}; exp = '0;
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL inlist_idle: got %h want %h", obs, exp); end
    $display("ldm: base register in list, loaded value kept");
  endtask

  task automatic test_stall;
    mem_ready = 1'b1;
    launch(1'b1, 16'h0003, 32'h400, 4'd9, 1'b1, 1'b0, 1'b0);
    mem_rdata = 32'h51;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      start = (i == 1);
      reg_list = 16'hFFFF;
      obs = {mem_read_en, mem_write_en, mem_addr, rf_src, WB_EN, done};
      exp = {1'b1, 1'b0, 32'h404, 4'd1, (i == 0) ? 1'b1 : 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL stall_hold%0d: got %h want %h", i, obs, exp); end
      tick();
    end
    start = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h52;
    obs = {mem_read_en, mem_addr, WB_EN, done};
    exp = {1'b1, 32'h404, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL stall_release: got %h want %h", obs, exp); end
    tick();
    obs = {done, mem_read_en, WB_EN, WB_Dest, WB_Res};
    exp = {1'b1, 1'b0, 1'b1, 4'd1, 32'h52};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL stall_done: got %h want %h", obs, exp); end
    tick();
    $display("stall: 3-cycle wait on second transfer absorbed");
  endtask

  task automatic test_empty;
    launch(1'b0, 16'h0000, 32'h700, 4'd3, 1'b1, 1'b0, 1'b1);
    obs = {done, busy, mem_read_en, mem_write_en, WB_EN};
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL empty_done: got %h want %h", obs, exp); end
    tick();
    obs = {done, busy, mem_read_en, mem_write_en, WB_EN}; exp = '0;
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL empty_idle: got %h want %h", obs, exp); end
    $display("empty: list 0 completes with no transfers");
  endtask

  task automatic test_reset_mid;
    mem_ready = 1'b0;
    launch(1'b0, 16'h00F0, 32'h500, 4'd1, 1'b1, 1'b0, 1'b1);
    tick();
    obs = {mem_write_en, mem_addr, rf_src, busy};
    exp = {1'b1, 32'h500, 4'd4, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL midrst_pre: got %h want %h", obs, exp); end
    #2 rst = 1'b1;
    #1;
    obs = {busy, done, mem_read_en, mem_write_en, WB_EN}; exp = '0;
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL midrst_async: got %h want %h", obs, exp); end
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    launch(1'b1, 16'h0001, 32'h600, 4'd5, 1'b1, 1'b1, 1'b0);
    mem_rdata = 32'h77;
    obs = {mem_read_en, mem_addr, rf_src};
    exp = {1'b1, 32'h604, 4'd0};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL midrst_restart: got %h want %h", obs, exp); end
    tick();
    obs = {done, WB_EN, WB_Dest, WB_Res};
    exp = {1'b1, 1'b1, 4'd0, 32'h77};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL midrst_done: got %h want %h", obs, exp); end
    tick();
    $display("reset mid-transfer: recovered with new start");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'hC0DE0000 | i;
    rst = 1'b1; start = 1'b0; is_load = 1'b0; reg_list = '0; base_addr = '0;
    base_reg = '0; up = 1'b0; pre = 1'b0; writeback = 1'b0; mem_ready = 1'b1; mem_rdata = '0;
    test_reset();
    test_stm();
    test_ldm_down();
    test_ldm_base_in_list();
    test_stall();
    test_empty();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
